// File: rtl/dsp_preadd_mac_pipe_if.sv
// Stream bundle for the pre-add/multiply pipe: input beat channel (s_*)
// and output channel (m_*). The "master" modport is the side that sources
// input beats and sinks results; "slave" is the datapath itself.
interface dsp_preadd_mac_pipe_if #(
  parameter int DW = 8,
  parameter int OW = 2*DW+9
);
  logic                 s_tvalid;
  logic                 s_tready;
  logic signed [DW-1:0] s_a;
  logic signed [DW-1:0] s_b;
  logic signed [DW-1:0] s_c;
  logic                 s_sub;
  logic                 s_tlast;
  logic                 m_tvalid;
  logic                 m_tready;
  logic signed [OW-1:0] m_tdata;
  logic                 m_tlast;

  modport master (
    output s_tvalid, s_a, s_b, s_c, s_sub, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast
  );

  modport slave (
    input  s_tvalid, s_a, s_b, s_c, s_sub, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast
  );
endinterface

// File: rtl/dsp_preadd_mac_pipe.sv
// dsp_preadd_mac_pipe: 3-stage (a +/- b) * c datapath with valid/ready
// handshake and a single global stall.
//   S1: pre-add/sub in DW+1 bits
//   S2: exact signed product in 2*DW+1 bits
//   S3: output register (sign-extended to OW)
// Optional macro DSP_ACC_EN turns S3 into a frame accumulator that only
// presents a result on the tlast beat of each frame.
module dsp_preadd_mac_pipe #(
  parameter int DW = 8,
  parameter int OW = 2*DW+9
) (
  input logic                  clk,
  input logic                  rst,
  dsp_preadd_mac_pipe_if.slave bus
);
  localparam int PW = DW + 1;
  localparam int MW = 2*DW + 1;

  generate
    if (OW < MW) begin : g_ow_check
      $error("dsp_preadd_mac_pipe: OW must be >= 2*DW+1");
    end
  endgenerate

  // Whole pipe freezes only when a presented result is not taken.
  logic w_stall;
  assign w_stall      = bus.m_tvalid && !bus.m_tready;
  assign bus.s_tready = !w_stall;

  // ---------------- S1: pre-adder ----------------
  logic signed [PW-1:0] w_a_x, w_b_x, w_pre;
  assign w_a_x = bus.s_a;
  assign w_b_x = bus.s_b;
  assign w_pre = bus.s_sub ? (w_a_x - w_b_x) : (w_a_x + w_b_x);

  logic                 r_v1;
  logic signed [PW-1:0] r_pre;
  logic signed [DW-1:0] r_c1;
  logic                 r_last1;

  // Capture accepted beat; data held (not cleared) when no beat arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_pre   <= '0;
      r_c1    <= '0;
      r_last1 <= 1'b0;
    end else if (!w_stall) begin
      r_v1 <= bus.s_tvalid;
      if (bus.s_tvalid) begin
        r_pre   <= w_pre;
        r_c1    <= bus.s_c;
        r_last1 <= bus.s_tlast;
      end
    end
  end

  // ---------------- S2: multiplier ----------------
  logic signed [MW-1:0] w_pre_x, w_c_x, w_prod;
  assign w_pre_x = r_pre;
  assign w_c_x   = r_c1;
  assign w_prod  = w_pre_x * w_c_x;

  logic                 r_v2;
  logic signed [MW-1:0] r_prod;
  logic                 r_last2;

  // Register the exact product of the S1 beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_prod  <= '0;
      r_last2 <= 1'b0;
    end else if (!w_stall) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_prod  <= w_prod;
        r_last2 <= r_last1;
      end
    end
  end

  // ---------------- S3: output / accumulator ----------------
  logic signed [OW-1:0] w_prod_x;
  assign w_prod_x = r_prod;

  logic                 r_v3;
  logic signed [OW-1:0] r_out;
  logic                 r_last3;

`ifdef DSP_ACC_EN
  logic                 r_first;
  logic signed [OW-1:0] w_acc_nxt;
  // First beat of a frame starts from zero; sum wraps modulo 2^OW.
  assign w_acc_nxt = (r_first ? '0 : r_out) + w_prod_x;

  // Absorb every beat into the sum; only a tlast beat raises m_tvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3    <= 1'b0;
      r_out   <= '0;
      r_last3 <= 1'b0;
      r_first <= 1'b1;
    end else if (!w_stall) begin
      r_v3 <= r_v2 && r_last2;
      if (r_v2) begin
        r_out   <= w_acc_nxt;
        r_last3 <= r_last2;
        r_first <= r_last2;
      end
    end
  end
`else
  // One result per beat; tlast passes straight through with its beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3    <= 1'b0;
      r_out   <= '0;
      r_last3 <= 1'b0;
    end else if (!w_stall) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_out   <= w_prod_x;
        r_last3 <= r_last2;
      end
    end
  end
`endif

  assign bus.m_tvalid = r_v3;
  assign bus.m_tdata  = r_out;
  assign bus.m_tlast  = r_last3;

endmodule
